// File: rtl/sr_flag_arbiter_pkg.sv
// Shared definitions for the SR flag arbiter: op encoding and op field width.
package sr_arb_pkg;

    localparam int OPW = 2;

    typedef logic [OPW-1:0] op_t;

    localparam op_t OP_NOP = 2'b00;
    localparam op_t OP_SET = 2'b01;
    localparam op_t OP_RST = 2'b10;
    localparam op_t OP_BAD = 2'b11;

endpackage

// File: rtl/sr_flag_arbiter_if.sv
// Request/grant bus between control agents and the SR flag arbiter.
interface sr_flag_arbiter_if
    import sr_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int NFLAGS = 8,
    parameter int IDXW   = $clog2(NFLAGS)
);

    logic [NREQ-1:0]      req;
    logic [OPW*NREQ-1:0]  op;
    logic [IDXW*NREQ-1:0] flag_idx;
    logic [NREQ-1:0]      gnt;
    logic                 err;
    logic [NFLAGS-1:0]    flags;
    logic                 busy;

    modport master (
        output req, op, flag_idx,
        input  gnt, err, flags, busy
    );

    modport slave (
        input  req, op, flag_idx,
        output gnt, err, flags, busy
    );

endinterface

// File: rtl/sr_flag_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester after 'last', wrapping.
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [PW-1:0]   last,
    output logic            valid,
    output logic [PW-1:0]   pick
);

    // Rotate so bit 0 is the requester just after the last winner.
    logic [NREQ-1:0] rot;
    assign rot = NREQ'({eligible, eligible} >> (int'(last) + 1));

    // Lowest set bit of the rotated vector wins; map the offset back to an index.
    always_comb begin
        valid = 1'b0;
        pick  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                valid = 1'b1;
                pick  = PW'((int'(last) + 1 + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/sr_flag_arbiter.sv
// SR flag bank shared by NREQ requesters; one round-robin granted op per clock.
module sr_flag_arbiter
    import sr_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int NFLAGS = 8,
    parameter int IDXW   = $clog2(NFLAGS)
) (
    input logic              clk,
    input logic              rst,
    sr_flag_arbiter_if.slave bus
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]     last;
    logic [NREQ-1:0]   eligible;
    logic              pick_valid;
    logic [PW-1:0]     pick;
    op_t               sel_op;
    logic [IDXW-1:0]   sel_idx;
    logic              sel_err;
    logic              sel_write;
    logic [NREQ-1:0]   gnt_next;
    logic [NFLAGS-1:0] flags_next;

    // A requester granted this cycle is masked so it cannot be served twice while it drops req.
    assign eligible = bus.req & ~bus.gnt;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .eligible (eligible),
        .last     (last),
        .valid    (pick_valid),
        .pick     (pick)
    );

    // Select the winner's op and target, and build the one-hot grant.
    always_comb begin
        sel_op   = OP_NOP;
        sel_idx  = '0;
        gnt_next = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_valid && (pick == PW'(i))) begin
                sel_op      = bus.op[OPW*i +: OPW];
                sel_idx     = bus.flag_idx[IDXW*i +: IDXW];
                gnt_next[i] = 1'b1;
            end
        end
        sel_err   = pick_valid && ((sel_op == OP_BAD) || (int'(sel_idx) >= NFLAGS));
        sel_write = pick_valid && !sel_err && ((sel_op == OP_SET) || (sel_op == OP_RST));
    end

    // Apply the granted SET/RESET to the addressed flag; everything else leaves the bank alone.
    always_comb begin
        flags_next = bus.flags;
        for (int f = 0; f < NFLAGS; f++) begin
            if (sel_write && (sel_idx == IDXW'(f))) begin
                flags_next[f] = (sel_op == OP_SET);
            end
        end
    end

    // Registered outputs and round-robin pointer; reset restores requester 0 as highest priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.gnt   <= '0;
            bus.err   <= 1'b0;
            bus.busy  <= 1'b0;
            bus.flags <= '0;
            last      <= PW'(NREQ - 1);
        end else begin
            bus.gnt   <= gnt_next;
            bus.err   <= sel_err;
            bus.busy  <= |bus.req;
            bus.flags <= flags_next;
            if (pick_valid) begin
                last <= pick;
            end
        end
    end

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Bench for sr_flag_arbiter: directed scenarios plus random requester traffic,
// checked by a scoreboard fed from a behavioural model of the arbitration rules.
module tb_sr_flag_arbiter;

    localparam int NREQ   = 4;
    localparam int NFLAGS = 8;
    localparam int IDXW   = 4;

    typedef struct {
        logic [NREQ-1:0]   gnt;
        logic              err;
        logic [NFLAGS-1:0] flags;
        logic              busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    sr_flag_arbiter_if #(.NREQ(NREQ), .NFLAGS(NFLAGS), .IDXW(IDXW)) bus ();

    sr_flag_arbiter #(.NREQ(NREQ), .NFLAGS(NFLAGS), .IDXW(IDXW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Requester-side stimulus state
    bit [NREQ-1:0] cur_req;
    int            cur_op  [NREQ];
    int            cur_idx [NREQ];
    bit            pend    [NREQ];

    // Reference model state: flag bank, last winner, grant shown last cycle
    bit [NFLAGS-1:0] m_flags;
    int              m_last;
    bit [NREQ-1:0]   m_gnt;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Drive one cycle of inputs, predict the outcome of the coming edge, queue it.
    task automatic drive_cycle(input bit r);
        exp_t e;
        int   winner;
        rst     = r;
        bus.req = cur_req;
        for (int i = 0; i < NREQ; i++) begin
            bus.op[2*i +: 2]             = 2'(cur_op[i]);
            bus.flag_idx[IDXW*i +: IDXW] = IDXW'(cur_idx[i]);
        end
        if (r) begin
            m_flags = '0;
            m_gnt   = '0;
            m_last  = NREQ - 1;
            e.gnt   = '0;
            e.err   = 1'b0;
            e.busy  = 1'b0;
        end else begin
            winner = -1;
            for (int k = 1; k <= NREQ; k++) begin
                int c;
                c = (m_last + k) % NREQ;
                if (winner < 0 && cur_req[c] && !m_gnt[c]) winner = c;
            end
            e.gnt  = '0;
            e.err  = 1'b0;
            e.busy = (cur_req != '0);
            if (winner >= 0) begin
                e.gnt[winner] = 1'b1;
                if (cur_op[winner] == 3 || cur_idx[winner] >= NFLAGS) e.err = 1'b1;
                else if (cur_op[winner] == 1) m_flags[cur_idx[winner]] = 1'b1;
                else if (cur_op[winner] == 2) m_flags[cur_idx[winner]] = 1'b0;
                m_last = winner;
            end
            m_gnt = e.gnt;
        end
        e.flags = m_flags;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic set_req(input int i, input int o, input int ix);
        cur_req[i] = 1'b1;
        cur_op[i]  = o;
        cur_idx[i] = ix;
    endtask

    // Monitor: every falling edge, compare DUT outputs against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("sb_gnt",   32'(bus.gnt),   32'(e.gnt));
                cmp("sb_err",   32'(bus.err),   32'(e.err));
                cmp("sb_flags", 32'(bus.flags), 32'(e.flags));
                cmp("sb_busy",  32'(bus.busy),  32'(e.busy));
            end
        end
    end

    // Stimulus
    initial begin
        cur_req = '0;
        for (int i = 0; i < NREQ; i++) begin
            cur_op[i] = 0; cur_idx[i] = 0; pend[i] = 1'b0;
        end
        bus.req = '0; bus.op = '0; bus.flag_idx = '0;
        m_flags = '0; m_gnt = '0; m_last = NREQ - 1;

        // Reset held two cycles with every requester asking
        for (int i = 0; i < NREQ; i++) set_req(i, 1, i);
        for (int c = 0; c < 2; c++) begin
            drive_cycle(1);
            cmp("rst_gnt",   32'(bus.gnt),   32'h0);
            cmp("rst_err",   32'(bus.err),   32'h0);
            cmp("rst_flags", 32'(bus.flags), 32'h0);
        end

        // Round robin after release; each requester drops once it sees its grant
        drive_cycle(0); cmp("rr_g0", 32'(bus.gnt), 32'h1);
        cur_req[0] = 1'b0;
        drive_cycle(0); cmp("rr_g1", 32'(bus.gnt), 32'h2);
        cur_req[1] = 1'b0;
        drive_cycle(0); cmp("rr_g2", 32'(bus.gnt), 32'h4);
        cur_req[2] = 1'b0;
        drive_cycle(0); cmp("rr_g3", 32'(bus.gnt), 32'h8);
        cmp("rr_flags", 32'(bus.flags), 32'h0F);
        cmp("rr_busy", 32'(bus.busy), 32'h1);
        cur_req = '0;
        drive_cycle(0); cmp("idle_gnt", 32'(bus.gnt), 32'h0);
        cmp("idle_busy", 32'(bus.busy), 32'h0);

        // Single SET then RESET of flag 3 by requester 1
        drive_cycle(1);
        set_req(1, 1, 3);
        drive_cycle(0); cmp("set_gnt", 32'(bus.gnt), 32'h2);
        cmp("set_flags", 32'(bus.flags), 32'h08);
        set_req(1, 2, 3);
        drive_cycle(0); cmp("mask_gnt", 32'(bus.gnt), 32'h0);
        drive_cycle(0); cmp("clr_gnt", 32'(bus.gnt), 32'h2);
        cmp("clr_flags", 32'(bus.flags), 32'h00);
        cur_req = '0;
        drive_cycle(0);

        // Same-flag conflict: requester 0 SET, requester 2 RESET on flag 5
        drive_cycle(1);
        set_req(0, 1, 5); set_req(2, 2, 5);
        drive_cycle(0); cmp("cf_gnt0", 32'(bus.gnt), 32'h1);
        cmp("cf_flags0", 32'(bus.flags), 32'h20);
        cur_req[0] = 1'b0;
        drive_cycle(0); cmp("cf_gnt2", 32'(bus.gnt), 32'h4);
        cmp("cf_flags2", 32'(bus.flags), 32'h00);
        cur_req = '0;
        drive_cycle(0);

        // Invalid op and out-of-range index leave the bank unchanged
        set_req(1, 1, 2);
        drive_cycle(0); cmp("inv_pre_err", 32'(bus.err), 32'h0);
        cmp("inv_pre_flags", 32'(bus.flags), 32'h04);
        cur_req = '0; set_req(3, 3, 2);
        drive_cycle(0); cmp("bad_op_gnt", 32'(bus.gnt), 32'h8);
        cmp("bad_op_err", 32'(bus.err), 32'h1);
        cmp("bad_op_flags", 32'(bus.flags), 32'h04);
        cur_req = '0; set_req(2, 1, 9);
        drive_cycle(0); cmp("bad_idx_gnt", 32'(bus.gnt), 32'h4);
        cmp("bad_idx_err", 32'(bus.err), 32'h1);
        cmp("bad_idx_flags", 32'(bus.flags), 32'h04);
        cur_req = '0;
        drive_cycle(0); cmp("err_pulse", 32'(bus.err), 32'h0);

        // Reset mid-stream after two grants; order restarts at requester 0
        drive_cycle(1);
        for (int i = 0; i < NREQ; i++) set_req(i, 1, 4 + i);
        drive_cycle(0); cmp("ms_g0", 32'(bus.gnt), 32'h1);
        cur_req[0] = 1'b0;
        drive_cycle(0); cmp("ms_g1", 32'(bus.gnt), 32'h2);
        cmp("ms_flags", 32'(bus.flags), 32'h30);
        cur_req = '1;
        drive_cycle(1); cmp("ms_rst_flags", 32'(bus.flags), 32'h0);
        cmp("ms_rst_gnt", 32'(bus.gnt), 32'h0);
        drive_cycle(0); cmp("ms_restart", 32'(bus.gnt), 32'h1);
        cur_req = '0;
        drive_cycle(0);

        // Random requester traffic with occasional drops and resets
        for (int cyc = 0; cyc < 2000; cyc++) begin
            bit r;
            r = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (pend[i] && m_gnt[i]) pend[i] = 1'b0;
                if (pend[i] && $urandom_range(0, 39) == 0) pend[i] = 1'b0;
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i]    = 1'b1;
                    cur_op[i]  = int'($urandom_range(0, 3));
                    cur_idx[i] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(8, 15))
                                                              : int'($urandom_range(0, 7));
                end
                cur_req[i] = pend[i];
            end
            drive_cycle(r);
        end

        cur_req = '0;
        drive_cycle(0);
        repeat (3) @(negedge clk);
        cmp("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
